// File: rtl/axi_lite_uart_responder.sv
// AXI4-lite slave exposing a UART-Lite style register map (RX/TX/STAT/CTRL)
// backed by two byte FIFOs fed/drained by host-side streams.

module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] push_data,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    logic [7:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // A clear discards everything, including any push or pop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module axi_lite_uart_responder #(
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_awaddr,
    input  logic [2:0]  axi_awprot,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    output logic [1:0]  axi_bresp,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [31:0] axi_araddr,
    input  logic [2:0]  axi_arprot,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    input  logic        rx_in_valid,
    output logic        rx_in_ready,
    input  logic [7:0]  rx_in_data,
    output logic        tx_out_valid,
    input  logic        tx_out_ready,
    output logic [7:0]  tx_out_data
);
    localparam logic [1:0] REG_RX   = 2'd0;
    localparam logic [1:0] REG_TX   = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    logic       aw_hs;
    logic       ar_hs;
    logic       tx_write;
    logic       tx_overflow;
    logic       tx_push;
    logic       tx_clear;
    logic       rx_clear;
    logic       rx_pop;
    logic       tx_full;
    logic       tx_empty;
    logic       rx_full;
    logic       rx_empty;
    logic [7:0] rx_head;
    logic       unused_bits;

    assign unused_bits = ^{axi_awaddr[31:4], axi_awaddr[1:0], axi_awprot,
                           axi_wdata[31:8], axi_wstrb[3:1],
                           axi_araddr[31:4], axi_araddr[1:0], axi_arprot};

    // AW and W are only ever taken together, so one handshake covers both.
    assign aw_hs       = (w_state == W_IDLE) && axi_awvalid && axi_wvalid && !rst;
    assign axi_awready = aw_hs;
    assign axi_wready  = aw_hs;
    assign axi_arready = (r_state == R_IDLE) && !rst;
    assign ar_hs       = axi_arready && axi_arvalid;
    assign axi_rresp   = 2'b00;

    assign tx_write    = aw_hs && (axi_awaddr[3:2] == REG_TX) && axi_wstrb[0];
    assign tx_overflow = tx_write && tx_full;
    assign tx_push     = tx_write && !tx_full;
    assign tx_clear    = aw_hs && (axi_awaddr[3:2] == REG_CTRL) && axi_wstrb[0] && axi_wdata[0];
    assign rx_clear    = aw_hs && (axi_awaddr[3:2] == REG_CTRL) && axi_wstrb[0] && axi_wdata[1];
    assign rx_pop      = ar_hs && (axi_araddr[3:2] == REG_RX) && !rx_empty;

    assign rx_in_ready  = !rx_full;
    assign tx_out_valid = !tx_empty;

    uart_fifo #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (rx_clear),
        .push      (rx_in_valid),
        .pop       (rx_pop),
        .push_data (rx_in_data),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (tx_clear),
        .push      (tx_push),
        .pop       (tx_out_ready),
        .push_data (axi_wdata[7:0]),
        .head      (tx_out_data),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state    <= W_IDLE;
            axi_bvalid <= 1'b0;
            axi_bresp  <= 2'b00;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        w_state    <= W_RESP;
                        axi_bvalid <= 1'b1;
                        axi_bresp  <= tx_overflow ? 2'b10 : 2'b00;
                    end
                end
                W_RESP: begin
                    if (axi_bready) begin
                        w_state    <= W_IDLE;
                        axi_bvalid <= 1'b0;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read data is captured at the AR handshake and held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= R_IDLE;
            axi_rvalid <= 1'b0;
            axi_rdata  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state    <= R_DATA;
                        axi_rvalid <= 1'b1;
                        case (axi_araddr[3:2])
                            REG_RX:   axi_rdata <= rx_empty ? 32'h0 : {24'h0, rx_head};
                            REG_STAT: axi_rdata <= {28'h0, tx_full, tx_empty, rx_full, !rx_empty};
                            default:  axi_rdata <= 32'h0;
                        endcase
                    end
                end
                R_DATA: begin
                    if (axi_rready) begin
                        r_state    <= R_IDLE;
                        axi_rvalid <= 1'b0;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_uart_responder.sv
// Self-checking bench for axi_lite_uart_responder: directed scenarios plus a
// randomized phase checked against queue-based FIFO models.

module tb_axi_lite_uart_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        axi_awvalid, axi_awready;
    logic [31:0] axi_awaddr;
    logic [2:0]  axi_awprot;
    logic        axi_wvalid, axi_wready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_bvalid, axi_bready;
    logic [1:0]  axi_bresp;
    logic        axi_arvalid, axi_arready;
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arprot;
    logic        axi_rvalid, axi_rready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        rx_in_valid, rx_in_ready;
    logic [7:0]  rx_in_data;
    logic        tx_out_valid, tx_out_ready;
    logic [7:0]  tx_out_data;

    int check_count = 0;
    int fail_count  = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic       last_tx_valid;
    logic [7:0] last_tx_data;

    axi_lite_uart_responder dut (
        .clk(clk), .rst(rst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .rx_in_valid(rx_in_valid), .rx_in_ready(rx_in_ready), .rx_in_data(rx_in_data),
        .tx_out_valid(tx_out_valid), .tx_out_ready(tx_out_ready), .tx_out_data(tx_out_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_stat();
        return {28'h0, tx_q.size() == 16, tx_q.size() == 0, rx_q.size() == 16, rx_q.size() != 0};
    endfunction

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n = 0;
        axi_awaddr = addr; axi_wdata = data; axi_wstrb = strb;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        @(negedge clk);
        while (!axi_awready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!axi_awready) checkOutput("aw_timeout", 32'(axi_awready), 32'h1);
        checkOutput("wready_with_awready", 32'(axi_wready), 32'(axi_awready));
        @(posedge clk); #1;
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        last_tx_valid = tx_out_valid;
        last_tx_data  = tx_out_data;
        checkOutput("bvalid_next_cycle", 32'(axi_bvalid), 32'h1);
        resp = axi_bresp;
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        int n = 0;
        axi_araddr = addr; axi_arvalid = 1'b1;
        @(negedge clk);
        while (!axi_arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!axi_arready) checkOutput("ar_timeout", 32'(axi_arready), 32'h1);
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
        checkOutput("rvalid_next_cycle", 32'(axi_rvalid), 32'h1);
        checkOutput("rresp", 32'(axi_rresp), 32'h0);
        data = axi_rdata;
        @(posedge clk); #1;
        checkOutput("rvalid_drop", 32'(axi_rvalid), 32'h0);
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_in_valid = 1'b1; rx_in_data = b;
        @(negedge clk);
        checkOutput("rx_in_ready", 32'(rx_in_ready), 32'(rx_q.size() < 16));
        @(posedge clk); #1;
        if (rx_q.size() < 16) rx_q.push_back(b);
        rx_in_valid = 1'b0;
    endtask

    task automatic drain_tx(input int count);
        for (int i = 0; i < count; i++) begin
            tx_out_ready = 1'b1;
            @(negedge clk);
            checkOutput("tx_out_valid", 32'(tx_out_valid), 32'h1);
            checkOutput("tx_out_data", 32'(tx_out_data), 32'(tx_q.pop_front()));
            @(posedge clk); #1;
        end
        tx_out_ready = 1'b0;
    endtask

    task automatic read_rx_checked(input string tag);
        logic [31:0] d;
        logic [31:0] exp;
        exp = (rx_q.size() != 0) ? 32'(rx_q.pop_front()) : 32'h0;
        axi_read(32'h0, d);
        checkOutput(tag, d, exp);
    endtask

    task automatic read_stat_checked(input string tag);
        logic [31:0] d;
        logic [31:0] exp;
        exp = model_stat();
        axi_read(32'h8, d);
        checkOutput(tag, d, exp);
    endtask

    task automatic write_tx_checked(input logic [7:0] b, input logic [3:0] strb);
        logic [1:0] resp;
        logic [1:0] exp;
        exp = (strb[0] && tx_q.size() == 16) ? 2'b10 : 2'b00;
        if (strb[0] && tx_q.size() < 16) tx_q.push_back(b);
        axi_write(32'h4, {24'h0, b}, strb, resp);
        checkOutput("tx_bresp", 32'(resp), 32'(exp));
    endtask

    // One random operation against the model.
    task automatic applyStimulus();
        logic [1:0]  resp;
        logic [31:0] d;
        logic [3:0]  strb;
        logic [1:0]  bits;
        int op = $urandom_range(0, 15);
        strb = 4'($urandom_range(0, 15));
        if (op < 4) begin
            push_rx(8'($urandom));
        end else if (op < 8) begin
            write_tx_checked(8'($urandom), (op == 7) ? strb : 4'h1);
        end else if (op < 10) begin
            read_rx_checked("rand_rx_read");
        end else if (op == 10) begin
            read_stat_checked("rand_stat");
        end else if (op == 11) begin
            bits = 2'($urandom_range(0, 3));
            if (strb[0] && bits[0]) tx_q.delete();
            if (strb[0] && bits[1]) rx_q.delete();
            axi_write(32'hC, {30'h0, bits}, strb, resp);
            checkOutput("rand_ctrl_bresp", 32'(resp), 32'h0);
        end else if (op == 12) begin
            if (tx_q.size() != 0) drain_tx(1);
            else begin
                @(negedge clk);
                checkOutput("tx_idle_valid", 32'(tx_out_valid), 32'h0);
                @(posedge clk); #1;
            end
        end else if (op == 13) begin
            axi_write($urandom_range(0, 1) ? 32'h0 : 32'h8, $urandom, 4'hF, resp);
            checkOutput("ignored_write_bresp", 32'(resp), 32'h0);
        end else begin
            axi_read($urandom_range(0, 1) ? 32'h4 : 32'hC, d);
            checkOutput("zero_reg_read", d, 32'h0);
        end
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;

        rst = 1'b1;
        axi_awvalid = 0; axi_awaddr = 0; axi_awprot = 0;
        axi_wvalid = 0; axi_wdata = 0; axi_wstrb = 0;
        axi_bready = 1; axi_arvalid = 0; axi_araddr = 0; axi_arprot = 0;
        axi_rready = 1; rx_in_valid = 0; rx_in_data = 0; tx_out_ready = 0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_bvalid", 32'(axi_bvalid), 32'h0);
        checkOutput("reset_rvalid", 32'(axi_rvalid), 32'h0);
        checkOutput("reset_rdata", axi_rdata, 32'h0);
        checkOutput("reset_arready", 32'(axi_arready), 32'h0);
        checkOutput("reset_tx_valid", 32'(tx_out_valid), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Scenario 1: status after reset
        axi_read(32'h8, d);
        checkOutput("stat_after_reset", d, 32'h4);

        // Scenario 2: RX stream bytes read back in order
        push_rx(8'h41);
        push_rx(8'h42);
        read_stat_checked("stat_rx_valid");
        axi_read(32'h0, d); checkOutput("rx_first", d, 32'h41);
        axi_read(32'h0, d); checkOutput("rx_second", d, 32'h42);
        axi_read(32'h0, d); checkOutput("rx_empty_read", d, 32'h0);
        rx_q.delete();
        read_stat_checked("stat_rx_drained");

        // Scenario 3: single TX write appears on the stream next cycle
        axi_write(32'h4, 32'h5A, 4'h1, resp);
        tx_q.push_back(8'h5A);
        checkOutput("tx_write_bresp", 32'(resp), 32'h0);
        checkOutput("tx_valid_after_write", 32'(last_tx_valid), 32'h1);
        checkOutput("tx_data_after_write", 32'(last_tx_data), 32'h5A);
        drain_tx(1);

        // Scenario 4: overflow the TX FIFO
        for (int i = 0; i < 17; i++) write_tx_checked(8'(i), 4'h1);
        axi_read(32'h8, d);
        checkOutput("stat_tx_full", d, 32'h8);
        drain_tx(16);

        // Scenario 5: back-pressure on the write response
        axi_bready = 1'b0;
        axi_awaddr = 32'h4; axi_wdata = 32'h11; axi_wstrb = 4'h1;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        @(negedge clk);
        checkOutput("bp_first_awready", 32'(axi_awready), 32'h1);
        @(posedge clk); #1;
        axi_wdata = 32'h22;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_bvalid_held", 32'(axi_bvalid), 32'h1);
            checkOutput("bp_awready_low", 32'(axi_awready), 32'h0);
            checkOutput("bp_bresp_stable", 32'(axi_bresp), 32'h0);
        end
        @(posedge clk); #1;
        axi_bready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("bp_second_awready", 32'(axi_awready), 32'h1);
        @(posedge clk); #1;
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        checkOutput("bp_second_bvalid", 32'(axi_bvalid), 32'h1);
        @(posedge clk); #1;
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        drain_tx(2);

        // Scenario 6: RX clear wins over a same-cycle stream push
        push_rx(8'hA1); push_rx(8'hA2); push_rx(8'hA3);
        axi_awaddr = 32'hC; axi_wdata = 32'h2; axi_wstrb = 4'h1;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        rx_in_valid = 1'b1; rx_in_data = 8'h77;
        @(negedge clk);
        checkOutput("clr_awready", 32'(axi_awready), 32'h1);
        @(posedge clk); #1;
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; rx_in_valid = 1'b0;
        checkOutput("clr_bresp", 32'(axi_bresp), 32'h0);
        @(posedge clk); #1;
        rx_q.delete();
        axi_read(32'h8, d);
        checkOutput("clr_stat_bit0", {31'h0, d[0]}, 32'h0);
        axi_read(32'h0, d);
        checkOutput("clr_rx_read", d, 32'h0);

        // Randomized phase
        for (int i = 0; i < 300; i++) applyStimulus();
        read_stat_checked("final_stat");

        // Reset while a write response is pending
        axi_bready = 1'b0;
        axi_awaddr = 32'h4; axi_wdata = 32'h99; axi_wstrb = 4'h1;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        @(posedge clk); #1;
        checkOutput("pre_reset_bvalid", 32'(axi_bvalid), 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("midreset_bvalid", 32'(axi_bvalid), 32'h0);
        checkOutput("midreset_awready", 32'(axi_awready), 32'h0);
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rx_q.delete(); tx_q.delete();
        @(posedge clk); #1;
        read_stat_checked("stat_after_midreset");

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end
endmodule
